// File: rtl/neuron_update.sv
// -----------------------------------------------------------------------------
// neuron_update
//
// Backward-pass companion to the combinational `neuron` forward datapath.
// It holds the N signed Q1.7 weights of one neuron. For each backward step it
// walks the inputs serially, one per cycle. For every element it produces the
// back-propagated error and applies the learning-rate-scaled gradient to the
// weight.
//
// Parameters:
//   N         number of inputs/weights per neuron
//   LR_SHIFT  learning rate is 2^-LR_SHIFT (arithmetic right shift of gradient)
//
// Ports:
//   clk        single clock, all state on rising edge
//   rst        asynchronous active-low reset
//   start      one-cycle request to begin a backward step (sampled in IDLE only)
//   delta      signed Q1.7 output error, captured on accepted start
//   x_flat     signed Q1.7 forward inputs, element i = bits [8i+7:8i]
//   load       write load_data into weight load_idx (IDLE, no start)
//   load_idx   weight index for load; indices >= N are ignored
//   load_data  signed Q1.7 weight value
//   busy       high while a step is in RUN or DONE
//   done       one-cycle pulse after the last weight is updated
//   w_flat     current weights, registered
//   err_flat   back-propagated errors of the last step, registered
// -----------------------------------------------------------------------------
module neuron_update #(
    parameter int unsigned N        = 4,
    parameter int unsigned LR_SHIFT = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [7:0]             delta,
    input  logic [8*N-1:0]         x_flat,
    input  logic                   load,
    input  logic [$clog2(N)-1:0]   load_idx,
    input  logic [7:0]             load_data,
    output logic                   busy,
    output logic                   done,
    output logic [8*N-1:0]         w_flat,
    output logic [8*N-1:0]         err_flat
);

    localparam int unsigned IdxW = $clog2(N);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e                 state;
    logic [IdxW-1:0]        idx;
    logic signed [7:0]      delta_r;
    logic signed [7:0]      x_r   [N];
    logic signed [7:0]      w_r   [N];
    logic signed [7:0]      err_r [N];
    logic                   busy_r;
    logic                   done_r;

    // Clamp a wide signed value into the signed 8-bit range.
    function automatic logic signed [7:0] sat8(input logic signed [16:0] v);
        if (v > 17'sd127) begin
            return 8'h7F;
        end else if (v < -17'sd128) begin
            return 8'h80;
        end else begin
            return v[7:0];
        end
    endfunction

    // ------------------------------------------------------------------
    // Per-element datapath for the element currently addressed by idx
    // ------------------------------------------------------------------
    logic signed [7:0]  w_cur;
    logic signed [7:0]  x_cur;
    logic signed [15:0] p_w;
    logic signed [15:0] p_x;
    logic signed [15:0] pw_sh;
    logic signed [15:0] g;
    logic signed [16:0] w_wide;
    logic signed [7:0]  err_new;
    logic signed [7:0]  w_new;

    always_comb begin
        w_cur   = w_r[idx];
        x_cur   = x_r[idx];
        p_w     = w_cur * delta_r;
        p_x     = x_cur * delta_r;
        pw_sh   = p_w >>> 7;
        // Gradient kept at full width; the only clamp is on the final weight.
        g       = (p_x >>> 7) >>> LR_SHIFT;
        w_wide  = {{9{w_cur[7]}}, w_cur} - {g[15], g};
        err_new = sat8({pw_sh[15], pw_sh});
        w_new   = sat8(w_wide);
    end

    // Loads with an out-of-range index are dropped.
    logic load_ok;
    assign load_ok = load && (32'(load_idx) < N);

    // ------------------------------------------------------------------
    // Control FSM and all state
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= StIdle;
            idx     <= '0;
            delta_r <= '0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            for (int i = 0; i < N; i++) begin
                x_r[i]   <= '0;
                w_r[i]   <= '0;
                err_r[i] <= '0;
            end
        end else begin
            done_r <= 1'b0;
            unique case (state)
                StIdle: begin
                    // start has priority over load in the same cycle.
                    if (start) begin
                        delta_r <= delta;
                        for (int i = 0; i < N; i++) begin
                            x_r[i] <= x_flat[8*i +: 8];
                        end
                        idx    <= '0;
                        busy_r <= 1'b1;
                        state  <= StRun;
                    end else if (load_ok) begin
                        w_r[load_idx] <= load_data;
                    end
                end
                StRun: begin
                    // err_new is built from the pre-update weight.
                    w_r[idx]   <= w_new;
                    err_r[idx] <= err_new;
                    if (idx == IdxW'(N - 1)) begin
                        done_r <= 1'b1;
                        state  <= StDone;
                    end else begin
                        idx <= idx + IdxW'(1);
                    end
                end
                StDone: begin
                    busy_r <= 1'b0;
                    state  <= StIdle;
                end
                default: begin
                    busy_r <= 1'b0;
                    state  <= StIdle;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs straight from registers
    // ------------------------------------------------------------------
    assign busy = busy_r;
    assign done = done_r;

    for (genvar i = 0; i < N; i++) begin : g_flat
        assign w_flat[8*i +: 8]   = w_r[i];
        assign err_flat[8*i +: 8] = err_r[i];
    end

endmodule
